// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the main control FSM and the HI/LO multiply-divide sequencer.
// The requester drives the i* signals; the sequencer drives busy/done and the HI/LO view.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             iStart;
   logic [1:0]       iOp;
   logic [WIDTH-1:0] iA;
   logic [WIDTH-1:0] iB;
   logic             iMTHI;
   logic             iMTLO;
   logic             oBusy;
   logic             oDone;
   logic [WIDTH-1:0] oHI;
   logic [WIDTH-1:0] oLO;

   modport master (
      output iStart, iOp, iA, iB, iMTHI, iMTLO,
      input  oBusy, oDone, oHI, oLO
   );

   modport slave (
      input  iStart, iOp, iA, iB, iMTHI, iMTLO,
      output oBusy, oDone, oHI, oLO
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; one bit per cycle, done pulse WIDTH+2 cycles after start.
// No queueing: start and MTHI/MTLO are dropped while busy, so the requester must hold off on oBusy.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input logic               iCLK,
   input logic               iRST,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

   typedef struct packed {
      logic             is_div;
      logic             sign_a;
      logic             sign_b;
      logic             b_zero;
      logic [WIDTH-1:0] a_raw;
      logic [WIDTH-1:0] opnd;
   } job_t;

   state_t             state, state_nxt;
   job_t               job;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc, acc_step;
   logic [WIDTH-1:0]   hi, lo;
   logic               done, busy;

   logic               signed_op;
   logic [WIDTH-1:0]   mag_a, mag_b;

   logic [WIDTH:0]     mul_sum, div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, hi_fix, lo_fix;

   always_comb begin
      signed_op = ~bus.iOp[0];
      mag_a     = (signed_op && bus.iA[WIDTH-1]) ? -bus.iA : bus.iA;
      mag_b     = (signed_op && bus.iB[WIDTH-1]) ? -bus.iB : bus.iB;
   end

   // acc is {HI,LO} for multiply and {remainder,quotient} for divide; job.opnd is the multiplicand or divisor
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, job.opnd};
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, job.opnd};
      div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, job.opnd}) : div_shift[WIDTH-1:0];
      if (job.is_div)
         acc_step = {div_rem, acc[WIDTH-2:0], div_ge};
      else if (acc[0])
         acc_step = {mul_sum, acc[WIDTH-1:1]};
      else
         acc_step = {1'b0, acc[2*WIDTH-1:1]};
   end

   always_comb begin
      prod_fix = (job.sign_a ^ job.sign_b) ? -acc : acc;
      quo_fix  = (job.sign_a ^ job.sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = job.sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      hi_fix   = rem_fix;
      lo_fix   = quo_fix;
      if (!job.is_div) begin
         {hi_fix, lo_fix} = prod_fix;
      end else if (job.b_zero) begin
         hi_fix = job.a_raw;
         lo_fix = '1;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.iStart) state_nxt = RUN;
         RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN) || (state == FIX);
   end

   // done is registered so it lines up with the cycle in which HI/LO already hold the result
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         job  <= '0;
         acc  <= '0;
         cnt  <= '0;
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
      end else begin
         done <= (state == FIX);
         case (state)
            IDLE: begin
               if (bus.iStart) begin
                  job.is_div <= bus.iOp[1];
                  job.sign_a <= signed_op & bus.iA[WIDTH-1];
                  job.sign_b <= signed_op & bus.iB[WIDTH-1];
                  job.b_zero <= (bus.iB == '0);
                  job.a_raw  <= bus.iA;
                  job.opnd   <= bus.iOp[1] ? mag_b : mag_a;
                  acc        <= {{WIDTH{1'b0}}, (bus.iOp[1] ? mag_a : mag_b)};
                  cnt        <= '0;
               end else begin
                  if (bus.iMTHI) hi <= bus.iA;
                  if (bus.iMTLO) lo <= bus.iA;
               end
            end
            RUN: begin
               acc <= acc_step;
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               hi <= hi_fix;
               lo <= lo_fix;
            end
            default: ;
         endcase
      end
   end

   assign bus.oBusy = busy;
   assign bus.oDone = done;
   assign bus.oHI   = hi;
   assign bus.oLO   = lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, multi-cycle corner sequences, and random ops
// compared against a plain 64-bit arithmetic reference.
module tb_muldiv_sequencer;
   logic iCLK;
   logic iRST;
   int   checks;
   int   errors;

   muldiv_sequencer_if #(.WIDTH(32)) bus ();

   muldiv_sequencer #(.WIDTH(32)) dut (
      .iCLK(iCLK),
      .iRST(iRST),
      .bus (bus)
   );

   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } vec_t;

   vec_t        vecs[9];
   logic [63:0] res;
   int          lat;
   int          bcnt;
   int          dones;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   // Reference result {HI,LO} from ordinary signed/unsigned 64-bit arithmetic
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = 64'(a);
      ub = 64'(b);
      p  = '0;
      case (op)
         2'b00:   p = sa * sb;
         2'b01:   p = ua * ub;
         default: begin
            if (b == 32'd0) begin
               p = {a, 32'hFFFF_FFFF};
            end else begin
               if (op == 2'b10) begin
                  q = sa / sb;
                  r = sa % sb;
               end else begin
                  q = ua / ub;
                  r = ua % ub;
               end
               p = {r[31:0], q[31:0]};
            end
         end
      endcase
      return p;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Waits for oDone; lat counts cycles after the start edge, bcnt counts cycles seen busy
   task automatic wait_done(output int l, output int bc);
      l  = 0;
      bc = 0;
      do begin
         @(negedge iCLK);
         bus.iStart = 1'b0;
         bus.iMTHI  = 1'b0;
         bus.iMTLO  = 1'b0;
         bus.iA     = $urandom;
         bus.iB     = $urandom;
         bus.iOp    = 2'($urandom);
         l++;
         if (bus.oBusy) bc++;
      end while (!bus.oDone && l < 100);
   endtask

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] r, output int l, output int bc);
      @(negedge iCLK);
      bus.iOp    = op;
      bus.iA     = a;
      bus.iB     = b;
      bus.iStart = 1'b1;
      wait_done(l, bc);
      r = {bus.oHI, bus.oLO};
   endtask

   task automatic mt_write(input logic hi_en, input logic lo_en, input logic [31:0] d);
      @(negedge iCLK);
      bus.iA    = d;
      bus.iMTHI = hi_en;
      bus.iMTLO = lo_en;
      @(negedge iCLK);
      bus.iMTHI = 1'b0;
      bus.iMTLO = 1'b0;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      iRST       = 1'b1;
      bus.iStart = 1'b0;
      bus.iOp    = 2'b00;
      bus.iA     = 32'd0;
      bus.iB     = 32'd0;
      bus.iMTHI  = 1'b0;
      bus.iMTLO  = 1'b0;

      vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
      vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5"};
      vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2"};
      vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        "divu_100by7"};
      vecs[4] = '{2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, "divu_by0"};
      vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};
      vecs[6] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1xm1"};
      vecs[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7bym2"};
      vecs[8] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0"};

      repeat (3) @(negedge iCLK);
      iRST = 1'b0;
      check("reset_busy", 64'(bus.oBusy), 64'd0);
      check("reset_done", 64'(bus.oDone), 64'd0);
      check("reset_hi",   64'(bus.oHI),   64'd0);
      check("reset_lo",   64'(bus.oLO),   64'd0);

      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bcnt);
         check({vecs[i].name, "_hi"},   64'(res[63:32]), 64'(vecs[i].hi));
         check({vecs[i].name, "_lo"},   64'(res[31:0]),  64'(vecs[i].lo));
         check({vecs[i].name, "_lat"},  64'(lat),        64'd34);
         check({vecs[i].name, "_busy"}, 64'(bcnt),       64'd33);
      end

      // MTHI alone, then both at once
      mt_write(1'b1, 1'b0, 32'h0000_CAFE);
      check("mthi_hi", 64'(bus.oHI), 64'h0000_CAFE);
      check("mthi_lo_kept", 64'(bus.oLO), 64'hFFFF_FFFF);
      mt_write(1'b1, 1'b1, 32'h1234_5678);
      check("mtboth_hi", 64'(bus.oHI), 64'h1234_5678);
      check("mtboth_lo", 64'(bus.oLO), 64'h1234_5678);

      // start wins over MTLO in the same cycle
      @(negedge iCLK);
      bus.iOp    = 2'b01;
      bus.iA     = 32'd6;
      bus.iB     = 32'd7;
      bus.iStart = 1'b1;
      bus.iMTLO  = 1'b1;
      wait_done(lat, bcnt);
      check("start_prio_lo", 64'(bus.oLO), 64'd42);
      check("start_prio_hi", 64'(bus.oHI), 64'd0);

      // start and MTLO during a run are dropped; HI/LO keep old values until done
      mt_write(1'b1, 1'b1, 32'h0000_1111);
      @(negedge iCLK);
      bus.iOp    = 2'b01;
      bus.iA     = 32'd3;
      bus.iB     = 32'd4;
      bus.iStart = 1'b1;
      lat = 0;
      do begin
         @(negedge iCLK);
         lat++;
         if (lat == 5) begin
            check("run_old_lo", 64'(bus.oLO), 64'h0000_1111);
            bus.iStart = 1'b1;
            bus.iMTLO  = 1'b1;
            bus.iOp    = 2'b11;
            bus.iA     = 32'h0000_DEAD;
         end else begin
            bus.iStart = 1'b0;
            bus.iMTLO  = 1'b0;
         end
      end while (!bus.oDone && lat < 100);
      check("ignore_lat", 64'(lat), 64'd34);
      check("ignore_res", {bus.oHI, bus.oLO}, 64'd12);
      @(negedge iCLK);
      check("ignore_no_restart", 64'(bus.oBusy), 64'd0);

      // reset in the middle of a multiply aborts it without any result
      mt_write(1'b1, 1'b1, 32'h0000_5555);
      @(negedge iCLK);
      bus.iOp    = 2'b00;
      bus.iA     = 32'hFFFF_FFFD;
      bus.iB     = 32'd5;
      bus.iStart = 1'b1;
      repeat (10) begin
         @(negedge iCLK);
         bus.iStart = 1'b0;
      end
      iRST = 1'b1;
      @(negedge iCLK);
      iRST = 1'b0;
      check("abort_busy", 64'(bus.oBusy), 64'd0);
      check("abort_hi",   64'(bus.oHI),   64'd0);
      check("abort_lo",   64'(bus.oLO),   64'd0);
      dones = 0;
      repeat (60) begin
         @(negedge iCLK);
         if (bus.oDone) dones++;
      end
      check("abort_no_done", 64'(dones), 64'd0);

      // back-to-back: a new start in the done cycle is accepted
      do_op(2'b11, 32'd100, 32'd7, res, lat, bcnt);
      check("b2b_first", res, {32'd2, 32'd14});
      bus.iOp    = 2'b00;
      bus.iA     = 32'hFFFF_FFFD;
      bus.iB     = 32'd5;
      bus.iStart = 1'b1;
      wait_done(lat, bcnt);
      check("b2b_lat", 64'(lat), 64'd34);
      check("b2b_second", {bus.oHI, bus.oLO}, 64'hFFFF_FFFF_FFFF_FFF1);

      for (int i = 0; i < 40; i++) begin
         logic [1:0]  op;
         logic [31:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = pick();
         b  = pick();
         do_op(op, a, b, res, lat, bcnt);
         check($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), res, model(op, a, b));
         check($sformatf("rand%0d_lat", i), 64'(lat), 64'd34);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
